// File: rtl/banco_registradores_sb.sv
// ============================================================================
// Module   : banco_registradores_sb
// Purpose  : XLEN x 2**ADDR_W register file, x0 hardwired to zero, with a
//            per-register busy scoreboard and a registered busy count.
// Option   : define BANCO_REGS_BYPASS_EN for write-through read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module banco_registradores_sb #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] rd,
   input  logic [XLEN-1:0]   Write_Data,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic [XLEN-1:0]   Register1,
   output logic [XLEN-1:0]   Register2,
   input  logic              issue,
   input  logic [ADDR_W-1:0] issue_rd,
   output logic              busy1,
   output logic              busy2,
   output logic [CNT_W-1:0]  busy_count
);

   localparam int C_NREG = 1 << ADDR_W;

   logic [XLEN-1:0]   mem_q [C_NREG];
   logic [XLEN-1:0]   mem_d [C_NREG];
   logic [C_NREG-1:0] busy_q;
   logic [C_NREG-1:0] busy_d;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;

   logic w_wr_en;
   logic w_iss_en;
   logic w_set;
   logic w_clr;

   assign w_wr_en  = RegWrite && (rd != '0);
   assign w_iss_en = issue && (issue_rd != '0);

   // The count moves only on genuine bit transitions; a set and a clear of
   // the same register in one cycle resolves to set, so it is not a clear.
   assign w_set = w_iss_en && !busy_q[issue_rd];
   assign w_clr = w_wr_en && busy_q[rd] && !(w_iss_en && (issue_rd == rd));

   always_comb begin
      for (int i = 0; i < C_NREG; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (w_wr_en) begin
         mem_d[rd] = Write_Data;
      end
   end

   always_comb begin
      busy_d = busy_q;
      if (w_wr_en) begin
         busy_d[rd] = 1'b0;
      end
      if (w_iss_en) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      count_d = count_q + CNT_W'(w_set) - CNT_W'(w_clr);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < C_NREG; i++) begin
            mem_q[i] <= '0;
         end
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < C_NREG; i++) begin
            mem_q[i] <= mem_d[i];
         end
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign busy_count = count_q;

   logic [XLEN-1:0] w_rd1_stored;
   logic [XLEN-1:0] w_rd2_stored;

   assign w_rd1_stored = (rs1 == '0) ? '0 : mem_q[rs1];
   assign w_rd2_stored = (rs2 == '0) ? '0 : mem_q[rs2];

`ifdef BANCO_REGS_BYPASS_EN
   logic w_fwd1;
   logic w_fwd2;

   assign w_fwd1 = w_wr_en && (rd == rs1);
   assign w_fwd2 = w_wr_en && (rd == rs2);

   assign Register1 = w_fwd1 ? Write_Data : w_rd1_stored;
   assign Register2 = w_fwd2 ? Write_Data : w_rd2_stored;

   // A forwarded register is no longer pending unless it is re-issued now.
   assign busy1 = (w_fwd1 && !(w_iss_en && (issue_rd == rs1))) ? 1'b0 : busy_q[rs1];
   assign busy2 = (w_fwd2 && !(w_iss_en && (issue_rd == rs2))) ? 1'b0 : busy_q[rs2];
`else
   assign Register1 = w_rd1_stored;
   assign Register2 = w_rd2_stored;
   assign busy1     = busy_q[rs1];
   assign busy2     = busy_q[rs2];
`endif

endmodule

`default_nettype wire

// File: tb/tb_banco_registradores_sb.sv
// ============================================================================
// Module   : tb_banco_registradores_sb
// Purpose  : Directed vector table plus hand-written corner sequences for
//            banco_registradores_sb (honours BANCO_REGS_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_banco_registradores_sb;

   localparam int XLEN   = 32;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 6;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              RegWrite = 1'b0;
   logic [ADDR_W-1:0] rd = '0;
   logic [XLEN-1:0]   Write_Data = '0;
   logic [ADDR_W-1:0] rs1 = '0;
   logic [ADDR_W-1:0] rs2 = '0;
   logic [XLEN-1:0]   Register1;
   logic [XLEN-1:0]   Register2;
   logic              issue = 1'b0;
   logic [ADDR_W-1:0] issue_rd = '0;
   logic              busy1;
   logic              busy2;
   logic [CNT_W-1:0]  busy_count;

   int checks = 0;
   int failures = 0;

   banco_registradores_sb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .RegWrite   (RegWrite),
      .rd         (rd),
      .Write_Data (Write_Data),
      .rs1        (rs1),
      .rs2        (rs2),
      .Register1  (Register1),
      .Register2  (Register2),
      .issue      (issue),
      .issue_rd   (issue_rd),
      .busy1      (busy1),
      .busy2      (busy2),
      .busy_count (busy_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] wrd;
      logic [XLEN-1:0]   wdata;
      logic              iss;
      logic [ADDR_W-1:0] ird;
      logic [ADDR_W-1:0] a1;
      logic [ADDR_W-1:0] a2;
      logic [XLEN-1:0]   e_r1;
      logic [XLEN-1:0]   e_r2;
      logic              e_b1;
      logic              e_b2;
      logic [CNT_W-1:0]  e_cnt;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one cycle of activity, clock it, then drop enables and settle.
   task automatic cycle(input logic we, input logic [ADDR_W-1:0] wrd, input logic [XLEN-1:0] wd,
                        input logic iss, input logic [ADDR_W-1:0] ird,
                        input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
      @(negedge clk);
      RegWrite = we; rd = wrd; Write_Data = wd;
      issue = iss; issue_rd = ird; rs1 = a1; rs2 = a2;
      @(posedge clk);
      #1;
      RegWrite = 1'b0; issue = 1'b0;
      #1;
   endtask

   initial begin
      //         we  rd  wdata          iss ird a1 a2  r1            r2            b1 b2 cnt
      vecs[0]  = '{0, 0, 32'h0,         0, 0,  0, 0,  32'h0,        32'h0,        0, 0, 0};
      vecs[1]  = '{1, 7, 32'h12345678,  0, 0,  7, 0,  32'h12345678, 32'h0,        0, 0, 0};
      vecs[2]  = '{1, 0, 32'hFFFFFFFF,  0, 0,  0, 7,  32'h0,        32'h12345678, 0, 0, 0};
      vecs[3]  = '{0, 0, 32'h0,         1, 3,  3, 9,  32'h0,        32'h0,        1, 0, 1};
      vecs[4]  = '{0, 0, 32'h0,         1, 9,  3, 9,  32'h0,        32'h0,        1, 1, 2};
      vecs[5]  = '{1, 3, 32'hAAAA0003,  0, 0,  3, 9,  32'hAAAA0003, 32'h0,        0, 1, 1};
      vecs[6]  = '{0, 0, 32'h0,         1, 4,  4, 9,  32'h0,        32'h0,        1, 1, 2};
      vecs[7]  = '{1, 4, 32'hA5,        1, 4,  4, 3,  32'hA5,       32'hAAAA0003, 1, 0, 2};
      vecs[8]  = '{0, 0, 32'h0,         1, 9,  9, 4,  32'h0,        32'hA5,       1, 1, 2};
      vecs[9]  = '{1, 5, 32'h55,        0, 0,  5, 9,  32'h55,       32'h0,        0, 1, 2};
      vecs[10] = '{1, 9, 32'h99,        1, 5,  5, 9,  32'h55,       32'h99,       1, 0, 2};
      vecs[11] = '{1, 4, 32'h44,        0, 0,  4, 5,  32'h44,       32'h55,       0, 1, 1};
      vecs[12] = '{1, 5, 32'h5,         0, 0,  5, 4,  32'h5,        32'h44,       0, 0, 0};
      vecs[13] = '{0, 0, 32'h0,         1, 0,  0, 0,  32'h0,        32'h0,        0, 0, 0};

      #1;
      check("reset_r1", Register1, 32'h0);
      check("reset_cnt", 32'(busy_count), 32'h0);
      check("reset_b1", 32'(busy1), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 14; i++) begin
         cycle(vecs[i].we, vecs[i].wrd, vecs[i].wdata, vecs[i].iss, vecs[i].ird, vecs[i].a1, vecs[i].a2);
         check($sformatf("v%0d_r1", i), Register1, vecs[i].e_r1);
         check($sformatf("v%0d_r2", i), Register2, vecs[i].e_r2);
         check($sformatf("v%0d_b1", i), 32'(busy1), 32'(vecs[i].e_b1));
         check($sformatf("v%0d_b2", i), 32'(busy2), 32'(vecs[i].e_b2));
         check($sformatf("v%0d_cnt", i), 32'(busy_count), 32'(vecs[i].e_cnt));
      end

      // Same-cycle write visibility on the read port.
      cycle(1, 6, 32'h11, 0, 0, 6, 0);
      @(negedge clk);
      RegWrite = 1'b1; rd = 5'd6; Write_Data = 32'h22; rs1 = 5'd6;
      issue = 1'b1; issue_rd = 5'd8; rs2 = 5'd8;
      #1;
`ifdef BANCO_REGS_BYPASS_EN
      check("byp_same_cycle", Register1, 32'h22);
`else
      check("byp_same_cycle", Register1, 32'h11);
`endif
      check("byp_issue_not_yet", 32'(busy2), 32'h0);
      @(posedge clk);
      #1;
      RegWrite = 1'b0; issue = 1'b0;
      #1;
      check("byp_next_cycle", Register1, 32'h22);
      check("byp_issue_seen", 32'(busy2), 32'h1);
      cycle(1, 8, 32'h88, 0, 0, 8, 8);
      check("clr_x8", 32'(busy_count), 32'h0);

      // Saturation: every register busy, x0 issue ignored, then drain.
      for (int r = 1; r < 32; r++) begin
         cycle(0, 0, 0, 1, 5'(r), 5'(r), 0);
      end
      check("sat_cnt31", 32'(busy_count), 32'd31);
      check("sat_b31", 32'(busy1), 32'h1);
      cycle(0, 0, 0, 1, 0, 0, 31);
      check("sat_x0_cnt", 32'(busy_count), 32'd31);
      check("sat_x0_b1", 32'(busy1), 32'h0);
      for (int r = 1; r < 32; r++) begin
         cycle(1, 5'(r), 32'h100 + 32'(r), 0, 0, 5'(r), 0);
         if (r == 16) begin
            check("drain_cnt_mid", 32'(busy_count), 32'd15);
            check("drain_data_mid", Register1, 32'h110);
         end
      end
      check("drain_cnt0", 32'(busy_count), 32'd0);
      check("drain_x31", Register1, 32'h11F);

      // Asynchronous reset asserted mid-cycle.
      cycle(1, 5, 32'hDEADBEEF, 1, 12, 5, 12);
      check("pre_rst_x5", Register1, 32'hDEADBEEF);
      check("pre_rst_cnt", 32'(busy_count), 32'd1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_x5", Register1, 32'h0);
      check("async_rst_cnt", 32'(busy_count), 32'h0);
      check("async_rst_b2", 32'(busy2), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      cycle(0, 0, 0, 1, 2, 2, 5);
      check("post_rst_b1", 32'(busy1), 32'h1);
      check("post_rst_cnt", 32'(busy_count), 32'd1);
      check("post_rst_x5", Register2, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/banco_registradores_sb.md
Name: banco_registradores_sb

Overview:
Parametrised successor of the single-issue register file: XLEN-wide, 2**ADDR_W-entry file with two asynchronous read ports and one synchronous write port. Adds a hardwired-zero register 0, per-register busy scoreboard (set at issue, cleared at writeback) and a busy-count output. Sits between decode (rs1/rs2/rd, issue) and writeback (RegWrite/rd/Write_Data), and feeds the hazard/stall logic.

Parameters:
XLEN, 32, data width of each register
ADDR_W, 5, register address width; NREG = 2**ADDR_W entries
CNT_W, 6, width of busy_count; must satisfy 2**CNT_W > NREG-1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
RegWrite  input  1  writeback enable
rd  input  ADDR_W  writeback destination
Write_Data  input  XLEN  writeback data
rs1  input  ADDR_W  read address A
rs2  input  ADDR_W  read address B
Register1  output  XLEN  read data A
Register2  output  XLEN  read data B
issue  input  1  an instruction writing issue_rd is dispatched this cycle
issue_rd  input  ADDR_W  destination of the issued instruction
busy1  output  1  rs1 has a pending write
busy2  output  1  rs2 has a pending write
busy_count  output  CNT_W  number of registers currently marked busy

Behaviour:
- Reset (reset=0, async): all entries and busy bits cleared to 0 immediately, independent of clk; busy_count=0; Register1/2=0; busy1/2=0. Removal of reset is synchronised by the integrator; the first clk edge after release behaves normally.
- Write: at posedge clk, if RegWrite and rd!=0, mem[rd] <= Write_Data. Writes to register 0 are discarded.
- Read: combinational, zero latency. Register 0 always reads 0.
- Scoreboard: at posedge clk, if issue and issue_rd!=0, busy[issue_rd] <= 1. If RegWrite and rd!=0, busy[rd] <= 0. busy[0] is constant 0.
- Simultaneous issue_rd==rd (nonzero), both enabled in the same cycle: set wins (busy stays 1). The data write still happens.
- Writeback to a register that is not busy: data written, busy unchanged (0), no error.
- Issue to a register already busy: stays busy, busy_count unchanged.
- busy1 = busy[rs1], busy2 = busy[rs2]: combinational from registered state. Same-cycle issue is not reflected until the next cycle.
- busy_count: registered, equals popcount(busy) after each edge. Update rule: +1 if a bit transitions 0->1, -1 if a bit transitions 1->0, unchanged if both or neither. Maximum NREG-1, so no wrap.
- With no issue and no RegWrite, all state holds.

Optional Feature:
Macro BANCO_REGS_BYPASS_EN.
- Defined: write-through forwarding. If RegWrite and rd!=0 and rd==rs1, Register1=Write_Data in the same cycle (likewise rs2/Register2). busy1/busy2 read 0 for that register unless issue_rd also equals it in the same cycle.
- Undefined: reads return the stored value. The new value is visible from the cycle after the write edge, and busy1/2 follow busy state only.

Test Plan:
- Reset: write 0xDEADBEEF to x5, drive reset=0 mid-cycle -> Register1(rs1=5)=0 before next clk edge; busy_count=0.
- Write/read: RegWrite, rd=7, Write_Data=0x12345678; next cycle rs1=7, rs2=0 -> Register1=0x12345678, Register2=0. Write 0xFFFFFFFF to x0 -> x0 still reads 0.
- Scoreboard: issue x3, then x9 -> busy_count=2 and busy1=1 with rs1=3; writeback x3 -> busy1=0, busy_count=1.
- Set/clear collision: x4 busy, same cycle issue_rd=4 and RegWrite rd=4 data 0xA5 -> busy[4]=1, busy_count unchanged, x4=0xA5.
- Bypass: x6=0x11, same cycle RegWrite rd=6 data 0x22 with rs1=6 -> Register1=0x22 with BANCO_REGS_BYPASS_EN defined, 0x11 without; both read 0x22 next cycle.
- Saturation: issue all of x1..x31 -> busy_count=31; issue x0 -> busy_count still 31; writeback all -> 0.
